// File: rtl/lcd_bus_decoder.sv
// Receive-side monitor for an 8080-style display write bus: classifies commands,
// tracks the CASET/RASET window and rebuilds RAMWR pixels. Optional stats: LCD_DECODER_STATS_EN.
module lcd_bus_decoder #(
    parameter int unsigned DEF_XE = 239,
    parameter int unsigned DEF_YE = 319
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        dcx,
    input  logic [7:0]  d,
    output logic        cmd_valid,
    output logic [7:0]  cmd,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        frame_done,
    output logic [7:0]  frame_count,
    output logic [7:0]  drop_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_CASET, S_RASET, S_RAMWR_HI, S_RAMWR_LO, S_IGNORE
    } state_t;

    logic       r_wr_s1, r_wr_s2, r_wr_s3, r_dcx_s1, r_dcx_s2;
    logic [7:0] r_d_s1, r_d_s2;
    logic       w_strobe;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_idx, w_idx_nx;
    logic [23:0] r_shadow, w_shadow_nx;
    logic [31:0] w_shadow;
    logic [15:0] r_xs, r_xe, r_ys, r_ye, r_cx, r_cy;
    logic [15:0] w_xs_nx, w_xe_nx, w_ys_nx, w_ye_nx, w_cx_nx, w_cy_nx;
    logic [7:0]  r_hi, w_hi_nx;
    logic        r_cmd_valid, w_cmd_valid_nx, r_pix_valid, w_pix_valid_nx;
    logic        r_frame_done, w_frame_done_nx;
    logic [7:0]  r_cmd, w_cmd_nx;
    logic [8:0]  r_pix_x, r_pix_y, w_pix_x_nx, w_pix_y_nx;
    logic [15:0] r_pix_color, w_pix_color_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_s1  <= 1'b0; r_wr_s2  <= 1'b0; r_wr_s3 <= 1'b0;
            r_dcx_s1 <= 1'b0; r_dcx_s2 <= 1'b0;
            r_d_s1   <= '0;   r_d_s2   <= '0;
        end else begin
            r_wr_s1  <= wr;     r_wr_s2  <= r_wr_s1; r_wr_s3 <= r_wr_s2;
            r_dcx_s1 <= dcx;    r_dcx_s2 <= r_dcx_s1;
            r_d_s1   <= d;      r_d_s2   <= r_d_s1;
        end
    end

    assign w_strobe = r_wr_s2 & ~r_wr_s3;
    assign w_shadow = {r_shadow, r_d_s2};

    always_comb begin
        w_state_nx      = r_state;
        w_idx_nx        = r_idx;
        w_shadow_nx     = r_shadow;
        w_xs_nx         = r_xs;
        w_xe_nx         = r_xe;
        w_ys_nx         = r_ys;
        w_ye_nx         = r_ye;
        w_cx_nx         = r_cx;
        w_cy_nx         = r_cy;
        w_hi_nx         = r_hi;
        w_cmd_nx        = r_cmd;
        w_cmd_valid_nx  = 1'b0;
        w_pix_valid_nx  = 1'b0;
        w_frame_done_nx = 1'b0;
        w_pix_x_nx      = r_pix_x;
        w_pix_y_nx      = r_pix_y;
        w_pix_color_nx  = r_pix_color;
        if (w_strobe) begin
            if (!r_dcx_s2) begin
                w_cmd_nx       = r_d_s2;
                w_cmd_valid_nx = 1'b1;
                w_idx_nx       = 2'd0;
                case (r_d_s2)
                    8'h2A:   w_state_nx = S_CASET;
                    8'h2B:   w_state_nx = S_RASET;
                    8'h2C: begin
                        w_state_nx = S_RAMWR_HI;
                        w_cx_nx    = r_xs;
                        w_cy_nx    = r_ys;
                    end
                    default: w_state_nx = S_IGNORE;
                endcase
            end else begin
                case (r_state)
                    S_CASET, S_RASET: begin
                        w_shadow_nx = w_shadow[23:0];
                        w_idx_nx    = r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            w_state_nx = S_IDLE;
                            if (r_state == S_CASET) begin
                                w_xs_nx = w_shadow[31:16];
                                w_xe_nx = w_shadow[15:0];
                            end else begin
                                w_ys_nx = w_shadow[31:16];
                                w_ye_nx = w_shadow[15:0];
                            end
                        end
                    end
                    S_RAMWR_HI: begin
                        w_hi_nx    = r_d_s2;
                        w_state_nx = S_RAMWR_LO;
                    end
                    S_RAMWR_LO: begin
                        w_pix_valid_nx  = 1'b1;
                        w_pix_x_nx      = r_cx[8:0];
                        w_pix_y_nx      = r_cy[8:0];
                        w_pix_color_nx  = {r_hi, r_d_s2};
                        w_frame_done_nx = (r_cx >= r_xe) && (r_cy >= r_ye);
                        // >= rather than == so a start>end window still wraps
                        if (r_cx >= r_xe) begin
                            w_cx_nx = r_xs;
                            w_cy_nx = (r_cy >= r_ye) ? r_ys : r_cy + 16'd1;
                        end else begin
                            w_cx_nx = r_cx + 16'd1;
                        end
                        w_state_nx = S_RAMWR_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_xs         <= '0;
            r_xe         <= 16'(DEF_XE);
            r_ys         <= '0;
            r_ye         <= 16'(DEF_YE);
            r_cx         <= '0;
            r_cy         <= '0;
            r_hi         <= '0;
            r_cmd        <= '0;
            r_cmd_valid  <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_color  <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_idx        <= w_idx_nx;
            r_shadow     <= w_shadow_nx;
            r_xs         <= w_xs_nx;
            r_xe         <= w_xe_nx;
            r_ys         <= w_ys_nx;
            r_ye         <= w_ye_nx;
            r_cx         <= w_cx_nx;
            r_cy         <= w_cy_nx;
            r_hi         <= w_hi_nx;
            r_cmd        <= w_cmd_nx;
            r_cmd_valid  <= w_cmd_valid_nx;
            r_pix_valid  <= w_pix_valid_nx;
            r_frame_done <= w_frame_done_nx;
            r_pix_x      <= w_pix_x_nx;
            r_pix_y      <= w_pix_y_nx;
            r_pix_color  <= w_pix_color_nx;
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd        = r_cmd;
    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_color  = r_pix_color;
    assign frame_done = r_frame_done;

`ifdef LCD_DECODER_STATS_EN
    logic       w_drop;
    logic [7:0] r_frame_count, r_drop_count;

    // a command arriving in RAMWR_LO discards the held high byte
    assign w_drop = w_strobe & ((r_dcx_s2 & (r_state == S_IDLE)) |
                                (~r_dcx_s2 & (r_state == S_RAMWR_LO)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (r_frame_done)
                r_frame_count <= r_frame_count + 8'd1;
            if (w_drop && (r_drop_count != 8'hFF))
                r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
`else
    assign frame_count = 8'd0;
    assign drop_count  = 8'd0;
`endif

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Scoreboard bench for lcd_bus_decoder: directed bus writes push expected commands
// and pixels; a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_lcd_bus_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr  = 1'b0;
    logic        dcx = 1'b0;
    logic [7:0]  d   = '0;
    logic        cmd_valid, pix_valid, frame_done;
    logic [7:0]  cmd, frame_count, drop_count;
    logic [8:0]  pix_x, pix_y;
    logic [15:0] pix_color;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cq[$];
    logic [34:0] pq[$];

`ifdef LCD_DECODER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    lcd_bus_decoder #(.DEF_XE(239), .DEF_YE(319)) dut (
        .clk(clk), .rst(rst), .wr(wr), .dcx(dcx), .d(d),
        .cmd_valid(cmd_valid), .cmd(cmd),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .frame_done(frame_done), .frame_count(frame_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic c, input logic [7:0] v);
        @(posedge clk); #2; dcx = c; d = v;
        repeat (2) @(posedge clk);
        #2 wr = 1'b1;
        repeat (3) @(posedge clk);
        #2 wr = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] v);
        cq.push_back(v);
        send(1'b0, v);
    endtask

    task automatic exp_pix(input int x, input int y, input logic [15:0] c, input logic fd);
        pq.push_back({fd, 9'(x), 9'(y), c});
    endtask

    task automatic send_pix(input logic [15:0] c);
        send(1'b1, c[15:8]);
        send(1'b1, c[7:0]);
    endtask

    // monitor: compares every output pulse against the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                if (cq.size() == 0) chk("cmd_unexpected", 64'(cmd_valid), 64'd0);
                else                chk("cmd", 64'(cmd), 64'(cq.pop_front()));
            end
            if (pix_valid) begin
                if (pq.size() == 0) chk("pix_unexpected", 64'(pix_valid), 64'd0);
                else chk("pix{fd,x,y,color}", 64'({frame_done, pix_x, pix_y, pix_color}),
                         64'(pq.pop_front()));
            end else if (frame_done) begin
                chk("frame_done_alone", 64'(frame_done), 64'd0);
            end
        end
    end

    task automatic summary;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", 64'({cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_color, frame_done}), 64'd0);
        chk("rst_counts", 64'({frame_count, drop_count}), 64'd0);
        @(posedge clk); #3 rst = 1'b0;

        // default window, with cmd_valid latency check against the raw wr rise
        cq.push_back(8'h2C);
        @(posedge clk); #2; dcx = 1'b0; d = 8'h2C;
        repeat (2) @(posedge clk);
        #2 wr = 1'b1;
        repeat (2) @(posedge clk); #1 chk("cmd_valid_early", 64'(cmd_valid), 64'd0);
        @(posedge clk); #1 chk("cmd_valid_3clk", 64'(cmd_valid), 64'd1);
        chk("cmd_value", 64'(cmd), 64'h2C);
        @(posedge clk); #1 chk("cmd_valid_1cyc", 64'(cmd_valid), 64'd0);
        wr = 1'b0;
        repeat (2) @(posedge clk);
        exp_pix(0, 0, 16'hF800, 1'b0);
        send(1'b1, 8'hF8); send(1'b1, 8'h00);

        // window setup x 10..12, y 5..5
        send_cmd(8'h2A); send(1, 8'h00); send(1, 8'h0A); send(1, 8'h00); send(1, 8'h0C);
        send_cmd(8'h2B); send(1, 8'h00); send(1, 8'h05); send(1, 8'h00); send(1, 8'h05);
        send_cmd(8'h2C);
        exp_pix(10, 5, 16'h1234, 1'b0); send_pix(16'h1234);
        exp_pix(11, 5, 16'h5678, 1'b0); send_pix(16'h5678);
        exp_pix(12, 5, 16'h9ABC, 1'b1); send_pix(16'h9ABC);

        // partial CASET then RAMWR: window must be untouched
        send_cmd(8'h2A); send(1, 8'h00); send(1, 8'h00);
        send_cmd(8'h2C);
        exp_pix(10, 5, 16'h1122, 1'b0); send_pix(16'h1122);

        // half pixel aborted by an ignored command, then absorbed data
        send(1, 8'h33);
        send_cmd(8'h36);
        send(1, 8'h55);
        chk("drop_after_half_pixel", 64'(drop_count), 64'(STATS));

        // row and frame wrap in a 2x2 window
        send_cmd(8'h2A); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'h01);
        send_cmd(8'h2B); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'h01);
        send_cmd(8'h2C);
        exp_pix(0, 0, 16'h0001, 1'b0); send_pix(16'h0001);
        exp_pix(1, 0, 16'h0002, 1'b0); send_pix(16'h0002);
        exp_pix(0, 1, 16'h0003, 1'b0); send_pix(16'h0003);
        exp_pix(1, 1, 16'h0004, 1'b1); send_pix(16'h0004);
        exp_pix(0, 0, 16'h0005, 1'b0); send_pix(16'h0005);
        chk("frame_count", 64'(frame_count), 64'(2 * STATS));
        chk("drop_unchanged", 64'(drop_count), 64'(STATS));
        exp_pix(1, 0, 16'h0007, 1'b0); send_pix(16'h0007);

        // async reset while a high byte is held
        send(1, 8'hA5);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("async_rst_outputs", 64'({cmd_valid, cmd, pix_valid, pix_x, pix_y, pix_color, frame_done}), 64'd0);
        chk("async_rst_counts", 64'({frame_count, drop_count}), 64'd0);
        @(posedge clk); #3 rst = 1'b0;
        send(1, 8'h77);
        chk("drop_after_reset", 64'(drop_count), 64'(STATS));
        send_cmd(8'h2C);
        exp_pix(0, 0, 16'h001F, 1'b0); send_pix(16'h001F);

        repeat (20) @(posedge clk);
        chk("cmd_queue_drained", 64'(cq.size()), 64'd0);
        chk("pix_queue_drained", 64'(pq.size()), 64'd0);
        summary();
        $finish;
    end

endmodule

// File: doc/lcd_bus_decoder.md
# lcd_bus_decoder

Receive-side decoder for the 8080-style parallel display write bus (`wr`, `dcx`, `D[7:0]`) driven by the image generator. It samples the bus, classifies command and parameter bytes, and tracks the CASET/RASET address window. It rebuilds the RAMWR pixel stream into (x, y, RGB565) pixel events. It sits beside the display as a bus monitor for the verification bench and for a future mirror output, and must never load or alter the bus.

## Interface
Parameters:
- `DEF_XE`, default 239: column-end value at reset.
- `DEF_YE`, default 319: row-end value at reset.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `wr`, in, 1: bus write strobe, asynchronous to `clk`. A byte is transferred on its rising edge.
- `dcx`, in, 1: 0 marks a command byte, 1 marks a data/parameter byte.
- `d`, in, 8: bus data.
- `cmd_valid`, out, 1: one-cycle pulse when a command byte is accepted.
- `cmd`, out, 8: last accepted command byte.
- `pix_valid`, out, 1: one-cycle pulse when a complete pixel is assembled.
- `pix_x`, out, 9: column of the pixel, low 9 bits of the cursor.
- `pix_y`, out, 9: row of the pixel.
- `pix_color`, out, 16: RGB565 value, first byte in bits [15:8].
- `frame_done`, out, 1: one-cycle pulse, coincident with `pix_valid`, when the pixel written is at (xe, ye).
- `frame_count`, out, 8: statistics output; see Configuration.
- `drop_count`, out, 8: statistics output; see Configuration.

## Operation
- **Input sampling:** `wr`, `dcx` and `d` each pass through a 2-flop synchronizer. A third `wr` flop provides edge detection.
- **Byte capture:** a byte strobe fires when the synchronized `wr` is 1 and its delayed copy is 0. The synchronized `dcx` and `d` are captured on that cycle.
- **Command byte (dcx=0):**
  - Accepted in every state. It aborts any partial parameter sequence or half pixel.
  - Sets `cmd` and pulses `cmd_valid`.
  - Next state is chosen by the command value:
    - 0x2A → CASET_P, parameter index 0.
    - 0x2B → RASET_P, parameter index 0.
    - 0x2C → RAMWR_HI, with cursor ← (xs, ys).
    - Any other value → IGNORE.
- **States:**
  - IDLE (reset): data bytes are dropped.
  - CASET_P and RASET_P: collect 4 parameters in order start_hi, start_lo, end_hi, end_lo into a 32-bit shadow register.
    - The shadow is committed to xs/xe (or ys/ye) only on the 4th byte.
    - After the commit, the state goes to IDLE.
    - Further data bytes in IDLE are dropped.
  - RAMWR_HI: the data byte is held as the high colour byte; go to RAMWR_LO.
  - RAMWR_LO: the data byte completes the pixel.
    - Emit `pix_valid` with the cursor and colour.
    - Advance the cursor, then return to RAMWR_HI.
  - IGNORE: data bytes are absorbed silently and are not counted as drops.
- **Cursor advance:** xs, xe, ys, ye and the cursor are 16-bit.
  - If x ≥ xe: x ← xs, and the row advances. Otherwise x ← x+1.
  - Row advance: if y ≥ ye, y ← ys. Otherwise y ← y+1.
  - `frame_done` fires when the emitted pixel has x ≥ xe and y ≥ ye.
  - Using ≥ guarantees a wrap when start > end.
- **Reset values:**
  - Window: xs=0, xe=DEF_XE, ys=0, ye=DEF_YE.
  - Cursor = (0, 0), state IDLE.
  - All outputs are 0.
- **Reset mid-operation:** clears everything asynchronously. Any byte whose edge is in flight is lost.

## Timing
- Let the raw `wr` first be sampled high at clock edge N.
  - The byte strobe occurs during the cycle after edge N+1.
  - `cmd_valid` or `pix_valid` is registered high after edge N+2, for exactly one cycle.
- Bus requirements on the producer:
  - `wr` low ≥ 2 clk and high ≥ 2 clk.
  - `d` and `dcx` stable from ≥ 1 clk before the `wr` rise to ≥ 3 clk after it.
- Throughput is one byte per 4 clk minimum. There is no backpressure, and outputs are not held.
- Window registers update on the cycle after the 4th parameter's strobe. A RAMWR issued afterwards uses the new window.

## Configuration
- `LCD_DECODER_STATS_EN` defined:
  - `frame_count` increments, wrapping, on each `frame_done`.
  - `drop_count` increments, saturating at 255, on each data byte dropped in IDLE and on each half pixel discarded by a command.
  - Both counters reset to 0.
- Macro undefined: both ports are tied to 8'd0 and no counter logic is built.

## Test plan
- **Window setup:** 0x2A, 00 0A 00 0C; 0x2B, 00 05 00 05; 0x2C; 6 bytes → 3 `pix_valid` at (10,5), (11,5), (12,5), colours as sent. `frame_done` fires with the 3rd pixel.
- **Reset defaults:** after reset, 0x2C then 2 bytes 0xF8 0x00 → pixel (0,0), colour 0xF800. `cmd`=0x2C, with one `cmd_valid` 3 clk after the raw `wr` rise.
- **Row and frame wrap:** window x 0..1, y 0..1, 5 pixels → (0,0) (1,0) (0,1) (1,1) (0,0). `frame_done` fires only on the 4th pixel.
- **Aborts:** CASET with 2 params then 0x2C → window unchanged. A half pixel followed by a command → no `pix_valid`, and `drop_count`=1 with `LCD_DECODER_STATS_EN`.
- **Ignored command:** 0x36 followed by 1 data byte → `cmd_valid` only, no `pix_valid`, `drop_count` unchanged.
- **Async reset:** `rst` asserted during RAMWR_LO → outputs 0 immediately. The next byte without a command is dropped.
